data_sram_slave: RTL and testbench

DATA_SRAM_SLAVE -- requirements
Module: data_sram_slave

---
 rtl/data_sram_slave.sv | 96 +++++++++
 tb/tb_data_sram_slave.sv | 123 ++++++++++++
 2 files changed

// File: rtl/data_sram_slave.sv
// data_sram_slave: fixed-latency 32-bit SRAM slave for a CPU data port with byte-enable stores.
// Define DSRAM_ALIGN_CHECK_EN to flag misaligned accesses with err and suppress their effect.
module data_sram_slave #(
   parameter int AW      = 10,
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic        wr,
   input  logic [1:0]  size,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        addr_ok,
   output logic        data_ok,
   output logic [31:0] rdata,
   output logic        err
);
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
   localparam logic [3:0] CNT_INIT = LATENCY > 1 ? 4'(LATENCY - 2) : 4'd0;
   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        wr_q, err_q;
   logic [1:0]  size_q;
   logic [31:0] addr_q, wdata_q, rdata_q;
   logic [31:0] mem [2**AW];
   logic        hs, enter_resp, a_wr, mis;
   logic [1:0]  a_size;
   logic [31:0] a_addr, a_wdata;
   logic [3:0]  be;
   logic [AW-1:0] idx;
   logic        unused_hi;
   assign addr_ok = state_q == IDLE;
   assign data_ok = state_q == RESP;
   assign rdata   = rdata_q;
   assign err     = err_q;
   assign hs      = req & addr_ok;
   // With LATENCY==1 the access completes straight from IDLE, so use the live request fields.
   assign a_wr    = addr_ok ? wr    : wr_q;
   assign a_size  = addr_ok ? size  : size_q;
   assign a_addr  = addr_ok ? addr  : addr_q;
   assign a_wdata = addr_ok ? wdata : wdata_q;
   assign idx     = a_addr[AW+1:2];
   assign unused_hi = ^a_addr[31:AW+2];
   assign be = a_size == 2'd0 ? 4'b0001 << a_addr[1:0] :
               a_size == 2'd1 ? (a_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
`ifdef DSRAM_ALIGN_CHECK_EN
   assign mis = (a_size == 2'd1 && a_addr[0]) || (a_size[1] && a_addr[1:0] != 2'd0);
`else
   assign mis = 1'b0;
`endif
   assign enter_resp = state_d == RESP && state_q != RESP;
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: if (hs) begin
            state_d = LATENCY == 1 ? RESP : WAIT;
            cnt_d   = CNT_INIT;
         end
         WAIT: begin
            state_d = cnt_q == 4'd0 ? RESP : WAIT;
            cnt_d   = cnt_q == 4'd0 ? cnt_q : cnt_q - 4'd1;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (hs) begin
            wr_q    <= wr;
            size_q  <= size;
            addr_q  <= addr;
            wdata_q <= wdata;
         end
         if (enter_resp) begin
            err_q <= mis;
            if (mis) rdata_q <= '0;
            else if (!a_wr) rdata_q <= mem[idx];
         end
      end
   end
   // Reset on the completing edge aborts the store.
   always_ff @(posedge clk) begin
      if (!rst && enter_resp && a_wr && !mis)
         for (int i = 0; i < 4; i++)
            if (be[i]) mem[idx][8*i +: 8] <= a_wdata[8*i +: 8];
   end
endmodule

// File: tb/tb_data_sram_slave.sv
// tb_data_sram_slave: directed and random accesses checked against a word-array memory model.
module tb_data_sram_slave;
   localparam int AW = 10;
   localparam int LATENCY = 2;
   localparam int WORDS = 2**AW;
   logic clk = 1'b0, rst, req, wr, addr_ok, data_ok, err;
   logic [1:0] size;
   logic [31:0] addr, wdata, rdata, rd;
   int total = 0, bad = 0;
   logic [31:0] model [int];

   data_sram_slave #(.AW(AW), .LATENCY(LATENCY)) dut (
      .clk(clk), .rst(rst), .req(req), .wr(wr), .size(size), .addr(addr), .wdata(wdata),
      .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata), .err(err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic bit lane_hit(input logic [1:0] s, input logic [31:0] a, input int b);
      if (s == 2'd0) return b == int'(a % 4);
      if (s == 2'd1) return b / 2 == int'(a % 4) / 2;
      return 1'b1;
   endfunction

   task automatic access(input logic w, input logic [1:0] s, input logic [31:0] a,
                         input logic [31:0] d, output logic [31:0] r, output logic e);
      int n;
      check("idle_addr_ok", 32'(addr_ok), 32'd1);
      req = 1'b1; wr = w; size = s; addr = a; wdata = d;
      @(posedge clk);
      @(negedge clk);
      req = 1'b0;
      n = 1;
      while (!data_ok && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("latency", 32'(n), 32'(LATENCY));
      r = rdata;
      e = err;
      @(negedge clk);
      check("strobe_one_cycle", 32'(data_ok), 32'd0);
   endtask

   task automatic op(input logic w, input logic [1:0] s, input logic [31:0] a,
                     input logic [31:0] d, output logic [31:0] r);
      logic e;
      bit mis;
      int wi;
      wi = int'((a >> 2) % WORDS);
      mis = 1'b0;
`ifdef DSRAM_ALIGN_CHECK_EN
      mis = (s == 2'd1 && a % 2 != 0) || (s >= 2'd2 && a % 4 != 0);
`endif
      access(w, s, a, d, r, e);
      check("err", 32'(e), 32'(mis));
      if (mis) check("mis_rdata", r, 32'd0);
      else if (!w) check("load", r, model[wi]);
      else for (int b = 0; b < 4; b++) if (lane_hit(s, a, b)) model[wi][8*b +: 8] = d[8*b +: 8];
   endtask

   initial begin
      rst = 1'b1; req = 1'b0; wr = 1'b0; size = 2'd0; addr = '0; wdata = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check("rst_addr_ok", 32'(addr_ok), 32'd1);
         check("rst_data_ok", 32'(data_ok), 32'd0);
         check("rst_rdata", rdata, 32'd0);
         @(negedge clk);
      end
      op(1'b1, 2'd2, 32'h10, 32'hDEADBEEF, rd);
      op(1'b0, 2'd2, 32'h10, 32'h0, rd);
      check("word_rw", rd, 32'hDEADBEEF);
      op(1'b1, 2'd2, 32'h20, 32'h11223344, rd);
      op(1'b1, 2'd0, 32'h22, 32'h00AA0000, rd);
      op(1'b0, 2'd2, 32'h20, 32'h0, rd);
      check("byte_merge", rd, 32'h11AA3344);
      op(1'b1, 2'd2, 32'h24, 32'h0, rd);
      op(1'b1, 2'd1, 32'h26, 32'hBEEF0000, rd);
      op(1'b0, 2'd2, 32'h24, 32'h0, rd);
      check("half_store", rd, 32'hBEEF0000);
      op(1'b1, 2'd2, 32'h30, 32'h5, rd);
      req = 1'b1; wr = 1'b1; size = 2'd2; addr = 32'h30; wdata = 32'h99;
      @(posedge clk);
      @(negedge clk);
      req = 1'b0;
      check("wait_addr_ok", 32'(addr_ok), 32'd0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_rdata", rdata, 32'd0);
      for (int i = 0; i < 3; i++) begin
         check("abort_data_ok", 32'(data_ok), 32'd0);
         @(negedge clk);
      end
      op(1'b0, 2'd2, 32'h30, 32'h0, rd);
      check("abort_no_write", rd, 32'h5);
      op(1'b1, 2'd2, 32'h40, 32'hCAFEF00D, rd);
      op(1'b1, 2'd2, 32'h41, 32'h12345678, rd);
      op(1'b0, 2'd2, 32'h40, 32'h0, rd);
`ifdef DSRAM_ALIGN_CHECK_EN
      check("misaligned_kept", rd, 32'hCAFEF00D);
`else
      check("misaligned_write", rd, 32'h12345678);
`endif
      for (int i = 0; i < 16; i++) op(1'b1, 2'd2, 32'h100 + 32'(4 * i), $urandom, rd);
      for (int i = 0; i < 150; i++)
         op(1'(($urandom % 2)), 2'($urandom % 4),
            ($urandom & 32'hFFFF_F000) | 32'h100 | 32'($urandom_range(0, 63)), $urandom, rd);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
